cache_fill_fsm: RTL

- Miss-handling state machine between the pipeline's cache arrays and the multi-cycle main memory.
- On a cache miss it reads one whole block from main memory: one 16-bit word per cycle, pipelined requests.
- It steers each returned word into the data array and writes the tag once the last word has arrived.
- One instance serves the instruction cache and one serves the data cache. fsm_busy stalls the pipeline stage that missed (IF or MEM).

---
 rtl/cache_fill_fsm.sv | 69 ++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one cache block from pipelined main memory after a miss.
// Define CACHE_FILL_CRIT_WORD_FIRST_EN to fetch the missing word first, wrapping within the block.
module cache_fill_fsm #(
  parameter int WORDS = 8,
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic memory_data_valid,
  output logic fsm_busy,
  output logic memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic write_data_array,
  output logic [$clog2(WORDS)-1:0] data_word_offset,
  output logic write_tag_array
);
  localparam int OW = $clog2(WORDS);
  localparam int LB = OW + 1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [OW:0] issue_cnt, issue_n;
  logic [OW-1:0] recv_cnt, recv_n, issue_lo, crit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      state <= state_n;
      base <= base_n;
      issue_cnt <= issue_n;
      recv_cnt <= recv_n;
    end
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crit <= '0;
    else if (state == IDLE && miss_detected) crit <= miss_address[LB-1:1];
`else
  assign crit = '0;
`endif
  // once all reads are issued the address parks on the last word requested
  assign issue_lo = issue_cnt[OW] ? '1 : issue_cnt[OW-1:0];
  assign memory_address = base | ADDR_W'({OW'(crit + issue_lo), 1'b0});
  assign data_word_offset = crit + recv_cnt;
  always_comb begin
    state_n = state;
    base_n = base;
    issue_n = issue_cnt;
    recv_n = recv_cnt;
    fsm_busy = state == FILL;
    memory_read_en = fsm_busy && !issue_cnt[OW];
    write_data_array = fsm_busy && memory_data_valid;
    write_tag_array = write_data_array && &recv_cnt;
    if (state == IDLE && miss_detected) begin
      state_n = FILL;
      base_n = miss_address & ~ADDR_W'(2 * WORDS - 1);
      issue_n = '0;
      recv_n = '0;
    end else if (fsm_busy) begin
      issue_n = issue_cnt + (OW + 1)'(memory_read_en);
      recv_n = recv_cnt + OW'(write_data_array);
      if (write_tag_array) state_n = IDLE;
    end
  end
endmodule
